sim_exit_monitor: RTL and testbench

- Harness-side stage directly upstream of the top-level test driver; it produces the `success` and `failure` levels that the driver samples each clock.
- It sinks a simple write channel tapped from the SoC's host-communication path and decodes writes to the `tohost` address into pass/fail plus an exit code.
- It also runs a liveness watchdog and a post-reset holdoff.
- The driver ends simulation on `success`; the harness routes `failure` into the driver's failure path.

---
 rtl/sim_exit_pkg.sv | 24 ++
 rtl/sim_exit_monitor_if.sv | 26 ++
 rtl/sim_watchdog_ctr.sv | 26 ++
 rtl/sim_exit_monitor.sv | 158 +++++++++++++++
 tb/tb_sim_exit_monitor.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_exit_pkg.sv
// Shared types and constants for the simulation exit monitor.
package sim_exit_pkg;

    // Monitor lifecycle: post-reset holdoff, live decoding, then one of two terminal states.
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    // Why the run failed; the encodings are what the test driver sees on fail_reason.
    typedef enum logic [1:0] {
        RSN_NONE    = 2'd0,
        RSN_EXIT    = 2'd1,
        RSN_BADCMD  = 2'd2,
        RSN_TIMEOUT = 2'd3
    } fail_reason_e;

    // Exit code reported on a watchdog timeout; callers slice it down to their code width.
    localparam int unsigned         MAX_CODE_W   = 64;
    localparam logic [MAX_CODE_W-1:0] TIMEOUT_CODE = '1;

endpackage

// File: rtl/sim_exit_monitor_if.sv
// Write channel tapped from the host-communication path into the exit monitor.
interface sim_exit_monitor_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // The SoC side issues writes.
    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    // The monitor sinks writes.
    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/sim_watchdog_ctr.sv
// Idle-cycle counter: flags a single cycle when the limit is reached with no activity.
module sim_watchdog_ctr (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] limit,
    output logic        expire
);
    logic [31:0] r_idle;

    // Expiry is seen in the same cycle the count sits at limit-1, so the owner can act on that edge.
    assign expire = enable && !clear && (r_idle == (limit - 32'd1));

    // Count idle enabled cycles; activity, leaving the enabled state, or expiry restart from zero.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_idle <= '0;
        end else if (clear || !enable || expire) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 32'd1;
        end
    end
endmodule

// File: rtl/sim_exit_monitor.sv
// Decodes tohost writes into sticky pass/fail levels for the top-level test driver,
// with a post-reset holdoff and an optional liveness watchdog.
module sim_exit_monitor
    import sim_exit_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       CODE_W      = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h8000_1000,
    parameter int unsigned       HOLDOFF     = 16,
    parameter int unsigned       WATCHDOG    = 0
) (
    input  logic              clock,
    input  logic              reset,
    sim_exit_monitor_if.slave wr,
    output logic              success,
    output logic              failure,
    output logic [1:0]        fail_reason,
    output logic [CODE_W-1:0] exit_code,
    output logic [63:0]       cycle_count
);
    // The holdoff counter only ever holds 0..HOLDOFF-1.
    localparam int unsigned HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int unsigned HOLD_LAST = (HOLDOFF == 0) ? 0 : HOLDOFF - 1;

    state_e            r_state;
    state_e            w_state_nxt;
    fail_reason_e      r_reason;
    fail_reason_e      w_reason_nxt;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [63:0]       r_cycles;

    logic [DATA_W-1:0] w_data;
    logic              w_run;
    logic              w_accept;
    logic              w_tohost;
    logic              w_hold_done;
    logic              w_expire;

    assign w_data      = wr.wr_data;
    assign w_run       = (r_state == ST_RUN);
    // Only RUN decodes writes; terminal states sink them without looking.
    assign w_accept    = wr.wr_valid && w_run;
    assign w_tohost    = (wr.wr_addr == TOHOST_ADDR);
    assign w_hold_done = (HOLDOFF == 0) || (r_hold_cnt == HOLD_W'(HOLD_LAST));

    // The watchdog exists only when a limit is configured; otherwise it never fires.
    generate
        if (WATCHDOG != 0) begin : g_watchdog
            sim_watchdog_ctr u_watchdog (
                .clock  (clock),
                .reset  (reset),
                .clear  (w_accept),
                .enable (w_run),
                .limit  (32'(WATCHDOG)),
                .expire (w_expire)
            );
        end else begin : g_no_watchdog
            assign w_expire = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the reason/code to latch; an accepted write takes priority over watchdog expiry.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_state_nxt  = r_state;
        w_reason_nxt = r_reason;
        w_code_nxt   = r_code;
        case (r_state)
            ST_HOLD: begin
                if (w_hold_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    // Non-tohost writes and a zero tohost write are heartbeats only.
                    if (w_tohost && (w_data != '0)) begin
                        if (w_data[0]) begin
                            w_code_nxt = w_data[CODE_W:1];
                            if (w_data[CODE_W:1] == '0) begin
                                w_state_nxt = ST_PASS;
                            end else begin
                                w_state_nxt  = ST_FAIL;
                                w_reason_nxt = RSN_EXIT;
                            end
                        end else begin
                            w_state_nxt  = ST_FAIL;
                            w_reason_nxt = RSN_BADCMD;
                            w_code_nxt   = w_data[CODE_W-1:0];
                        end
                    end
                end else if (w_expire) begin
                    w_state_nxt  = ST_FAIL;
                    w_reason_nxt = RSN_TIMEOUT;
                    w_code_nxt   = TIMEOUT_CODE[CODE_W-1:0];
                end
            end
            default: begin
            end
        endcase
    end

    // Moore outputs decoded from the state register only, so wr_* never reach them combinationally.
    always_comb begin
        wr.wr_ready = 1'b0;
        success     = 1'b0;
        failure     = 1'b0;
        case (r_state)
            ST_RUN:  wr.wr_ready = 1'b1;
            ST_PASS: begin
                wr.wr_ready = 1'b1;
                success     = 1'b1;
            end
            ST_FAIL: begin
                wr.wr_ready = 1'b1;
                failure     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Result registers, holdoff counter and the saturating cycle counter (frozen once terminal).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_reason   <= RSN_NONE;
            r_code     <= '0;
            r_hold_cnt <= '0;
            r_cycles   <= '0;
        end else begin
            r_reason <= w_reason_nxt;
            r_code   <= w_code_nxt;
            if ((r_state == ST_HOLD) && !w_hold_done) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
            if (((r_state == ST_HOLD) || w_run) && (r_cycles != '1)) begin
                r_cycles <= r_cycles + 64'd1;
            end
        end
    end

    assign fail_reason = r_reason;
    assign exit_code   = r_code;
    assign cycle_count = r_cycles;

endmodule

// File: tb/tb_sim_exit_monitor.sv
`timescale 1ns/1ps
// Self-checking bench: two monitor instances (holdoff+watchdog, and no holdoff/no watchdog)
// compared every cycle against a rule-level reference model.
module tb_sim_exit_monitor;
    localparam logic [31:0] TOHOST = 32'h8000_1000;
    localparam int unsigned HOLD_A = 16;
    localparam int unsigned WD_A   = 100;
    localparam int unsigned HOLD_B = 0;
    localparam int unsigned WD_B   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        succ_a, fail_a, succ_b, fail_b;
    logic [1:0]  rsn_a, rsn_b;
    logic [31:0] code_a, code_b;
    logic [63:0] cyc_a, cyc_b;

    sim_exit_monitor_if #(.ADDR_W(32), .DATA_W(64)) if_a ();
    sim_exit_monitor_if #(.ADDR_W(32), .DATA_W(64)) if_b ();

    sim_exit_monitor #(.HOLDOFF(HOLD_A), .WATCHDOG(WD_A)) u_dut_a (
        .clock(clk), .reset(rst_a), .wr(if_a), .success(succ_a), .failure(fail_a),
        .fail_reason(rsn_a), .exit_code(code_a), .cycle_count(cyc_a)
    );
    sim_exit_monitor #(.HOLDOFF(HOLD_B), .WATCHDOG(WD_B)) u_dut_b (
        .clock(clk), .reset(rst_b), .wr(if_b), .success(succ_b), .failure(fail_b),
        .fail_reason(rsn_b), .exit_code(code_b), .cycle_count(cyc_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit          sel_b;
    logic        cur_v;
    logic [31:0] cur_a;
    logic [63:0] cur_d;

    // Reference model: the outcome of the run expressed directly from the decode rules.
    int unsigned     m_holdoff, m_wd, m_idle;
    bit              m_done, m_succ, m_fail;
    logic [1:0]      m_reason;
    logic [31:0]     m_code;
    longint unsigned m_cycles;

    function automatic bit m_run();
        longint unsigned first_run;
        first_run = (m_holdoff == 0) ? 1 : m_holdoff;
        return !m_done && (m_cycles >= first_run);
    endfunction

    function automatic logic [100:0] expected();
        return {m_done || m_run(), m_succ, m_fail, m_reason, m_code, 64'(m_cycles)};
    endfunction

    function automatic logic [100:0] observed();
        if (sel_b) return {if_b.wr_ready, succ_b, fail_b, rsn_b, code_b, cyc_b};
        return {if_a.wr_ready, succ_a, fail_a, rsn_a, code_a, cyc_a};
    endfunction

    task automatic model_reset();
        m_holdoff = sel_b ? HOLD_B : HOLD_A;
        m_wd      = sel_b ? WD_B : WD_A;
        m_idle    = 0;
        m_done    = 0;
        m_succ    = 0;
        m_fail    = 0;
        m_reason  = 2'd0;
        m_code    = 32'd0;
        m_cycles  = 0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] a, input logic [63:0] d);
        bit run;
        run = m_run();
        if (m_done) return;
        if (m_cycles != 64'hFFFF_FFFF_FFFF_FFFF) m_cycles++;
        if (!run) return;
        if (v) begin
            m_idle = 0;
            if (a == TOHOST && d != 64'd0) begin
                m_done = 1;
                if (d[0]) begin
                    m_code = d[32:1];
                    if (m_code == 32'd0) m_succ = 1;
                    else begin
                        m_fail = 1;
                        m_reason = 2'd1;
                    end
                end else begin
                    m_fail = 1;
                    m_reason = 2'd2;
                    m_code = d[31:0];
                end
            end
        end else if (m_wd != 0 && m_idle == m_wd - 1) begin
            m_done = 1;
            m_fail = 1;
            m_reason = 2'd3;
            m_code = 32'hFFFF_FFFF;
        end else begin
            m_idle++;
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [63:0] d);
        cur_v = v; cur_a = a; cur_d = d;
        if (sel_b) begin
            if_b.wr_valid = v; if_b.wr_addr = a; if_b.wr_data = d;
            if_a.wr_valid = 1'b0;
        end else begin
            if_a.wr_valid = v; if_a.wr_addr = a; if_a.wr_data = d;
            if_b.wr_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(cur_v, cur_a, cur_d);
        #1;
    endtask

    // Pulse the selected instance's reset (the other stays in reset) and release it mid-cycle.
    task automatic apply_reset(input bit b, input logic v, input logic [31:0] a, input logic [63:0] d);
        sel_b = b;
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(v, a, d);
        @(posedge clk);
        @(negedge clk);
        if (b) rst_b = 1'b0;
        else   rst_a = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        sel_b = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(1'b0, 32'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (observed() !== 101'd0) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected all zero", observed());
        end
        sel_b = 1;
        n_checks++;
        if (observed() !== 101'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected all zero", observed());
        end
    endtask

    task automatic test_holdoff();
        apply_reset(0, 1'b1, TOHOST, 64'h1);
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL holdoff model cycle %0d: got %h expected %h", k, observed(), expected());
            end
            if (k < 16) begin
                n_checks++;
                if (if_a.wr_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL holdoff ready cycle %0d: got %b expected 0", k, if_a.wr_ready);
                end
            end
            if (k == 16) begin
                n_checks++;
                if ({if_a.wr_ready, succ_a} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL holdoff open: got ready/success %b expected 10", {if_a.wr_ready, succ_a});
                end
            end
        end
        n_checks++;
        if ({succ_a, fail_a, rsn_a, code_a, cyc_a} !== {1'b1, 1'b0, 2'd0, 32'd0, 64'd17}) begin
            n_fail++;
            $display("FAIL holdoff pass: got %b %b %0d %h %0d expected 1 0 0 0 17",
                     succ_a, fail_a, rsn_a, code_a, cyc_a);
        end
        drive(1'b0, 32'd0, 64'd0);
        repeat (3) tick();
        n_checks++;
        if (cyc_a !== 64'd17) begin
            n_fail++;
            $display("FAIL holdoff freeze: got %0d expected 17", cyc_a);
        end
    endtask

    task automatic test_exit_fail();
        apply_reset(0, 1'b0, 32'd0, 64'd0);
        repeat (16) tick();
        drive(1'b1, TOHOST, 64'h7);
        tick();
        drive(1'b1, TOHOST, 64'h1);
        n_checks++;
        if ({succ_a, fail_a, rsn_a, code_a} !== {1'b0, 1'b1, 2'd1, 32'd3}) begin
            n_fail++;
            $display("FAIL exit_code3: got %b %b %0d %h expected 0 1 1 3", succ_a, fail_a, rsn_a, code_a);
        end
        repeat (2) tick();
        drive(1'b0, 32'd0, 64'd0);
        n_checks++;
        if ({succ_a, fail_a, rsn_a, code_a, cyc_a} !== {1'b0, 1'b1, 2'd1, 32'd3, 64'd17}) begin
            n_fail++;
            $display("FAIL exit_frozen: got %b %b %0d %h %0d expected 0 1 1 3 17",
                     succ_a, fail_a, rsn_a, code_a, cyc_a);
        end
        n_checks++;
        if (observed() !== expected()) begin
            n_fail++;
            $display("FAIL exit model: got %h expected %h", observed(), expected());
        end
    endtask

    task automatic test_badcmd();
        apply_reset(0, 1'b0, 32'd0, 64'd0);
        repeat (16) tick();
        drive(1'b1, 32'h8000_1008, 64'h1);
        tick();
        drive(1'b1, TOHOST, 64'h0);
        n_checks++;
        if ({if_a.wr_ready, succ_a, fail_a} !== 3'b100) begin
            n_fail++;
            $display("FAIL near_addr: got %b expected 100", {if_a.wr_ready, succ_a, fail_a});
        end
        tick();
        drive(1'b1, TOHOST, 64'h8);
        n_checks++;
        if ({if_a.wr_ready, succ_a, fail_a} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_data: got %b expected 100", {if_a.wr_ready, succ_a, fail_a});
        end
        tick();
        drive(1'b0, 32'd0, 64'd0);
        n_checks++;
        if ({succ_a, fail_a, rsn_a, code_a} !== {1'b0, 1'b1, 2'd2, 32'd8}) begin
            n_fail++;
            $display("FAIL badcmd: got %b %b %0d %h expected 0 1 2 8", succ_a, fail_a, rsn_a, code_a);
        end
    endtask

    task automatic test_watchdog();
        apply_reset(0, 1'b0, 32'd0, 64'd0);
        repeat (16) tick();
        for (int k = 1; k <= 100; k++) begin
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL wd model run %0d: got %h expected %h", k, observed(), expected());
            end
            if (k == 99 && fail_a !== 1'b0) begin
                n_fail++;
                $display("FAIL wd early: got failure %b expected 0", fail_a);
            end
        end
        n_checks++;
        if ({fail_a, rsn_a, code_a} !== {1'b1, 2'd3, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL wd expire: got %b %0d %h expected 1 3 ffffffff", fail_a, rsn_a, code_a);
        end
        // Heartbeat on the expiry cycle wins and restarts the count.
        apply_reset(0, 1'b0, 32'd0, 64'd0);
        repeat (16) tick();
        repeat (99) tick();
        drive(1'b1, 32'h1234_0000, 64'h5);
        tick();
        drive(1'b0, 32'd0, 64'd0);
        n_checks++;
        if ({if_a.wr_ready, fail_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL wd heartbeat: got %b expected 10", {if_a.wr_ready, fail_a});
        end
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 99) begin
                n_checks++;
                if (fail_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wd restart early: got failure %b expected 0", fail_a);
                end
            end
        end
        n_checks++;
        if ({fail_a, rsn_a} !== {1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL wd restart expire: got %b %0d expected 1 3", fail_a, rsn_a);
        end
    endtask

    task automatic test_async_reset();
        apply_reset(0, 1'b0, 32'd0, 64'd0);
        repeat (16) tick();
        drive(1'b1, TOHOST, 64'h1);
        tick();
        drive(1'b0, 32'd0, 64'd0);
        n_checks++;
        if (succ_a !== 1'b1) begin
            n_fail++;
            $display("FAIL async pre: got success %b expected 1", succ_a);
        end
        @(posedge clk);
        #3;
        rst_a = 1'b1;
        #1;
        n_checks++;
        if (observed() !== 101'd0) begin
            n_fail++;
            $display("FAIL async clear: got %h expected all zero", observed());
        end
        @(negedge clk);
        rst_a = 1'b0;
        model_reset();
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) tick();
            n_checks++;
            if ({if_a.wr_ready, cyc_a} !== {(k >= 16), 64'(k)} || observed() !== expected()) begin
                n_fail++;
                $display("FAIL async rerun cycle %0d: got %h expected %h", k, observed(), expected());
            end
        end
    endtask

    task automatic test_holdoff_zero();
        apply_reset(1, 1'b1, TOHOST, 64'h1);
        n_checks++;
        if ({if_b.wr_ready, succ_b, cyc_b} !== {1'b0, 1'b0, 64'd0}) begin
            n_fail++;
            $display("FAIL h0 cycle0: got %b %b %0d expected 0 0 0", if_b.wr_ready, succ_b, cyc_b);
        end
        tick();
        n_checks++;
        if ({if_b.wr_ready, succ_b, cyc_b} !== {1'b1, 1'b0, 64'd1}) begin
            n_fail++;
            $display("FAIL h0 edge1: got %b %b %0d expected 1 0 1", if_b.wr_ready, succ_b, cyc_b);
        end
        tick();
        n_checks++;
        if ({succ_b, fail_b, cyc_b} !== {1'b1, 1'b0, 64'd2} || observed() !== expected()) begin
            n_fail++;
            $display("FAIL h0 edge2: got %h expected %h", observed(), expected());
        end
        // No watchdog on this instance: long idle must stay in RUN.
        apply_reset(1, 1'b0, 32'd0, 64'd0);
        repeat (300) tick();
        n_checks++;
        if ({if_b.wr_ready, fail_b, cyc_b} !== {1'b1, 1'b0, 64'd300}) begin
            n_fail++;
            $display("FAIL no_wd idle: got %b %b %0d expected 1 0 300", if_b.wr_ready, fail_b, cyc_b);
        end
    endtask

    task automatic test_random();
        for (int run = 0; run < 40; run++) begin
            int unsigned len;
            int unsigned rate;
            apply_reset(run[0], 1'b0, 32'd0, 64'd0);
            len  = $urandom_range(20, 200);
            rate = ($urandom_range(0, 3) == 0) ? 128 : 3;
            for (int k = 0; k < int'(len); k++) begin
                logic        v;
                logic [31:0] a;
                logic [63:0] d;
                v = ($urandom_range(1, rate) == 1);
                a = ($urandom_range(0, 3) == 0) ? TOHOST : (TOHOST ^ (32'h1 << $urandom_range(0, 31)));
                case ($urandom_range(0, 7))
                    0:       d = 64'd0;
                    1:       d = 64'd1;
                    2, 3:    d = {31'd0, 32'($urandom_range(1, 15)), 1'b1};
                    4, 5:    d = {$urandom, $urandom} & ~64'd1;
                    default: d = {$urandom, $urandom};
                endcase
                drive(v, a, d);
                tick();
                n_checks++;
                if (observed() !== expected()) begin
                    n_fail++;
                    $display("FAIL random run %0d cycle %0d: got %h expected %h", run, k, observed(), expected());
                end
            end
        end
        drive(1'b0, 32'd0, 64'd0);
    endtask

    initial begin
        if_a.wr_valid = 1'b0; if_a.wr_addr = '0; if_a.wr_data = '0;
        if_b.wr_valid = 1'b0; if_b.wr_addr = '0; if_b.wr_data = '0;
        test_reset();
        test_holdoff();
        test_exit_fail();
        test_badcmd();
        test_watchdog();
        test_async_reset();
        test_holdoff_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
